// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/IDIV: EDX:EAX / src -> EAX, EDX or #DE.
// One quotient bit per cycle behind a start/busy/done handshake.
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] p;
  logic [31:0] lo;
  logic [31:0] dsr;
  logic [4:0]  cnt;
  logic        sgn;
  logic        neg_q;
  logic        neg_r;
  logic        efault;

  logic [63:0] mag_dvd;
  logic [31:0] mag_dsr;
  logic        early;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;
  logic        late;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  always_comb begin
    mag_dvd = dividend;
    mag_dsr = divisor;
    if (is_signed && dividend[63]) mag_dvd = -dividend;
    if (is_signed && divisor[31])  mag_dsr = -divisor;
    early = (divisor == 32'd0) || (mag_dvd[63:32] >= mag_dsr);
  end

  // P stays below |divisor|, so the 32-bit difference is exact.
  always_comb begin
    trial = {p, lo[31]};
    ge    = trial >= {1'b0, dsr};
    diff  = trial[31:0] - dsr;
  end

  always_comb begin
    late  = sgn && (neg_q ? (lo > 32'h8000_0000) : lo[31]);
    q_fin = neg_q ? -lo : lo;
    r_fin = neg_r ? -p : p;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start) state_nx = early ? FIN : RUN;
      RUN:
        if (cnt == 5'd31) state_nx = FIN;
      FIN:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done      <= 1'b0;
      fault     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      p         <= '0;
      lo        <= '0;
      dsr       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      efault    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            p      <= mag_dvd[63:32];
            lo     <= mag_dvd[31:0];
            dsr    <= mag_dsr;
            cnt    <= '0;
            sgn    <= is_signed;
            neg_q  <= is_signed && (dividend[63] ^ divisor[31]);
            neg_r  <= is_signed && dividend[63];
            efault <= early;
          end
        end
        RUN: begin
          p   <= ge ? diff : trial[31:0];
          lo  <= {lo[30:0], ge};
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          done <= 1'b1;
          if (efault || late) begin
            fault     <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            fault     <= 1'b0;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: results, latency, faults, handshake, reset.
// Cycle 0 is the cycle in which start is high.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        fault;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .fault     (fault)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run(input string tag,
                     input logic sg,
                     input logic [63:0] dvd,
                     input logic [31:0] dsr,
                     input int lat,
                     input logic [31:0] eq,
                     input logic [31:0] er,
                     input logic ef,
                     input int poke);
    int k;
    int nbusy;
    bit seen;
    start     = 1'b1;
    is_signed = sg;
    dividend  = dvd;
    divisor   = dsr;
    nbusy     = 0;
    seen      = 0;
    k         = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      k = c;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      if (c == poke) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 64'd999;
        divisor   = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".seen"}, 64'(seen), 64'd1);
    chk({tag, ".lat"}, 64'(k), 64'(lat));
    chk({tag, ".busy"}, 64'(nbusy), 64'(lat - 1));
    chk({tag, ".bz0"}, 64'(busy), 64'd0);
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".f"}, 64'(fault), 64'(ef));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int ndone;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    idle(3);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.q", 64'(quotient), 64'd0);
    chk("rst.r", 64'(remainder), 64'd0);
    chk("rst.f", 64'(fault), 64'd0);
    rst_n = 1'b1;
    idle(2);

    run("udiv", 0, 64'd100, 32'd7, 34, 32'd14, 32'd2, 0, 0);
    idle(1);
    chk("done1", 64'(done), 64'd0);
    run("sneg", 1, 64'hFFFFFFFF_FFFFFFF9, 32'd2, 34,
        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
    idle(2);
    run("sdsr", 1, 64'd7, 32'hFFFFFFFE, 34,
        32'hFFFFFFFD, 32'd1, 0, 0);
    idle(2);
    run("ez", 0, 64'd55, 32'd0, 2, 32'd0, 32'd0, 1, 0);
    idle(2);
    run("ehi", 0, 64'h00000001_00000000, 32'd1, 2,
        32'd0, 32'd0, 1, 0);
    idle(2);
    run("lfix", 1, 64'hFFFFFFFF_80000000, 32'hFFFFFFFF, 34,
        32'd0, 32'd0, 1, 0);
    idle(2);
    run("lok", 1, 64'hFFFFFFFF_80000000, 32'd1, 34,
        32'h80000000, 32'd0, 0, 0);
    idle(2);
    run("big", 0, 64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 34,
        32'hFFFFFFFF, 32'd0, 0, 0);
    idle(2);
    run("poke", 0, 64'd1000, 32'd3, 34, 32'd333, 32'd1, 0, 10);
    run("b2b", 1, 64'hFFFFFFFF_FFFFFF9C, 32'd7, 34,
        32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0);
    idle(2);

    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 64'd77;
    divisor   = 32'd4;
    @(negedge clk);
    start = 1'b0;
    idle(14);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    chk("mrst.q", 64'(quotient), 64'd0);
    chk("mrst.r", 64'(remainder), 64'd0);
    chk("mrst.f", 64'(fault), 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mrst.nodone", 64'(ndone), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider for the `DIV`/`IDIV` commands; it consumes `alu_op_div` work issued by the execute stage's ALU control decode. It divides the 64-bit EDX:EAX dividend by a 32-bit source operand in one restoring step per cycle. It returns quotient (EAX) and remainder (EDX), or a divide-error fault (#DE). It sits beside the combinational ALU datapath and replaces a single-cycle divide with a start/done handshake.

## Interface

Parameters: none; widths are fixed by the 32-bit ISA.

- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a divide; accepted only in a cycle with `busy`=0.
- `is_signed` in 1: 1 = IDIV (two's complement), 0 = DIV; sampled with `start`.
- `dividend` in 64: EDX:EAX; sampled with `start`.
- `divisor` in 32: source operand; sampled with `start`.
- `busy` out 1: operation in progress; `start` is ignored while high.
- `done` out 1: one-cycle pulse; `quotient`, `remainder` and `fault` are valid from this cycle.
- `quotient` out 32: result for EAX; held until the next accepted `start`.
- `remainder` out 32: result for EDX; held until the next accepted `start`.
- `fault` out 1: #DE; set with `done`, held until the next accepted `start`.

## Operation

- **States:** IDLE, RUN, FIN.
- **Accept:** in IDLE, `start`=1 latches the operands.
  - Signed: take magnitudes |hi:lo| and |divisor|; record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Unsigned: magnitudes are the raw values.
- **Early fault, decided at accept:**
  - divisor == 0, or
  - magnitude hi word ≥ |divisor| (the quotient would need more than 32 bits).
  - Action: go straight to FIN with the fault flag set; no iterations run.
- **RUN:** exactly 32 iterations, one per cycle, driven by a 5-bit counter.
  - Each iteration: partial remainder P (33 bits) = {P[31:0], next dividend bit, MSB first}.
  - If P ≥ |divisor|: subtract |divisor| and shift 1 into Q; otherwise shift 0 into Q.
  - P starts as the magnitude hi word.
- **FIN (signed only):**
  - Negate Q if `neg_q`; negate P if `neg_r` (truncating division; remainder takes the dividend's sign).
  - Late fault: `neg_q`=1 and |Q| > 2^31, or `neg_q`=0 and |Q| > 2^31−1.
- **FIN outputs:**
  - Pulse `done` and return to IDLE.
  - On fault: `quotient` = `remainder` = 0 and `fault` = 1.
  - Otherwise: results are driven and `fault` = 0.
- **Width rules:** magnitude of −2^63 is taken as unsigned 2^63 with no overflow. |0x80000000| = 0x80000000 as unsigned.
- **Reset (`rst_n`=0 on an edge):**
  - State goes to IDLE.
  - `busy`, `done`, `fault`, `quotient` and `remainder` all go to 0.
  - Any in-flight operation is dropped and no `done` is issued for it.

## Timing

- **Normal operation**, `start` accepted in cycle 0:
  - `busy`=1 in cycles 1–33 (RUN 1–32, FIN-prep 33).
  - `done`=1 and `busy`=0 in cycle 34.
- **Early fault**, `start` accepted in cycle 0:
  - `busy`=1 in cycle 1.
  - `done`=1, `fault`=1, `busy`=0 in cycle 2.
- **Late signed fault:** same timing as normal operation (`done` in cycle 34).
- **Back-to-back:** a `start` in the cycle `done`=1 is accepted (`busy` is 0 there). No idle gap is required.
- **Busy overlap:** `start` while `busy`=1 is ignored and does not affect the in-flight operation.
- **Output timing:** outputs change only on the `done` cycle edge or on reset. `done` is never high for two consecutive cycles.

## Test plan

- **Unsigned divide:** DIV 64'd100 / 7 -> `done` in cycle 34, `quotient`=14, `remainder`=2, `fault`=0, `busy` high in cycles 1–33.
- **Signed divide:** IDIV 64'hFFFFFFFF_FFFFFFF9 (−7) / 2 -> `quotient`=32'hFFFFFFFD, `remainder`=32'hFFFFFFFF. Also 7 / −2 -> `quotient`=32'hFFFFFFFD, `remainder`=1.
- **Early faults:**
  - divisor 0 -> `done`, `fault`=1, results 0 in cycle 2.
  - DIV 64'h00000001_00000000 / 1 -> same early-fault response.
- **Late signed fault:**
  - IDIV 64'hFFFFFFFF_80000000 (−2^31) / 32'hFFFFFFFF -> `fault`=1 in cycle 34.
  - IDIV −2^31 / 1 -> `quotient`=32'h80000000, `fault`=0.
- **Handshake:**
  - `start` pulsed in cycle 10 of a run with different operands -> ignored; first result unchanged.
  - New `start` in the `done` cycle -> second `done` exactly 34 cycles later.
- **Reset mid-run:** `rst_n`=0 in cycle 15 -> next cycle `busy`=0, all outputs 0, and no `done` for 40 cycles.
